// File: rtl/axi_rd_arbiter.sv
// Read-side arbiter and address router: IFU/LSU masters -> CLINT/MEM slaves.
// One read transaction in flight at a time; unmapped reads are answered
// internally with a single DECERR beat.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise LSU has fixed priority on simultaneous requests.
module axi_rd_arbiter (
  input  logic        clock,
  input  logic        reset,
  // IFU master
  input  logic [31:0] ifu_araddr_i,
  input  logic [3:0]  ifu_arid_i,
  input  logic [7:0]  ifu_arlen_i,
  input  logic        ifu_arvalid_i,
  output logic        ifu_arready_o,
  output logic [63:0] ifu_rdata_o,
  output logic [1:0]  ifu_rresp_o,
  output logic        ifu_rlast_o,
  output logic [3:0]  ifu_rid_o,
  output logic        ifu_rvalid_o,
  input  logic        ifu_rready_i,
  // LSU master
  input  logic [31:0] lsu_araddr_i,
  input  logic [3:0]  lsu_arid_i,
  input  logic [7:0]  lsu_arlen_i,
  input  logic        lsu_arvalid_i,
  output logic        lsu_arready_o,
  output logic [63:0] lsu_rdata_o,
  output logic [1:0]  lsu_rresp_o,
  output logic        lsu_rlast_o,
  output logic [3:0]  lsu_rid_o,
  output logic        lsu_rvalid_o,
  input  logic        lsu_rready_i,
  // MEM slave
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arid_o,
  output logic [7:0]  mem_arlen_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic [63:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  input  logic        mem_rlast_i,
  input  logic [3:0]  mem_rid_i,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o,
  // CLINT slave
  output logic [31:0] clint_araddr_o,
  output logic        clint_arvalid_o,
  input  logic        clint_arready_i,
  input  logic [63:0] clint_rdata_i,
  input  logic [1:0]  clint_rresp_i,
  input  logic        clint_rlast_i,
  input  logic [3:0]  clint_rid_i,
  input  logic        clint_rvalid_i,
  output logic        clint_rready_o
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StErr} state_e;
  typedef enum logic [1:0] {TgtNone, TgtClint, TgtMem} target_e;

  state_e      state_q;
  target_e     target_q;
  logic        owner_lsu_q;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q;

  // Slave IDs are not used: the response ID is always the latched master ID.
  logic unused_rid;
  assign unused_rid = ^{clint_rid_i, mem_rid_i};

  logic        req_any;
  logic        tie_lsu;
  logic        grant_lsu;
  logic [31:0] win_addr;
  logic [3:0]  win_id;
  logic [7:0]  win_len;
  target_e     win_target;

  assign req_any   = ifu_arvalid_i | lsu_arvalid_i;
  assign grant_lsu = lsu_arvalid_i & (~ifu_arvalid_i | tie_lsu);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when LSU was granted last; reset value makes the first tie go to IFU.
  logic last_lsu_q;

  assign tie_lsu = ~last_lsu_q;

  // Round-robin pointer, updated on every grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lsu_q <= 1'b1;
    end else if (state_q == StIdle && req_any) begin
      last_lsu_q <= grant_lsu;
    end
  end
`else
  assign tie_lsu = 1'b1;
`endif

  // Winner request mux and fixed address-map decode.
  always_comb begin
    win_addr   = grant_lsu ? lsu_araddr_i : ifu_araddr_i;
    win_id     = grant_lsu ? lsu_arid_i   : ifu_arid_i;
    win_len    = grant_lsu ? lsu_arlen_i  : ifu_arlen_i;
    win_target = TgtNone;
    if (win_addr[31:16] == 16'h0200) begin
      win_target = TgtClint;
    end else if (win_addr[31:27] == 5'b10000) begin
      win_target = TgtMem;
    end
  end

  // Selected-slave and owner-side views of the handshake signals.
  logic        tgt_arready;
  logic        tgt_rvalid;
  logic [63:0] tgt_rdata;
  logic [1:0]  tgt_rresp;
  logic        tgt_rlast;
  logic        own_rready;

  always_comb begin
    tgt_arready = 1'b0;
    tgt_rvalid  = 1'b0;
    tgt_rdata   = 64'd0;
    tgt_rresp   = 2'b00;
    tgt_rlast   = 1'b0;
    if (target_q == TgtMem) begin
      tgt_arready = mem_arready_i;
      tgt_rvalid  = mem_rvalid_i;
      tgt_rdata   = mem_rdata_i;
      tgt_rresp   = mem_rresp_i;
      tgt_rlast   = mem_rlast_i;
    end else if (target_q == TgtClint) begin
      tgt_arready = clint_arready_i;
      tgt_rvalid  = clint_rvalid_i;
      tgt_rdata   = clint_rdata_i;
      tgt_rresp   = clint_rresp_i;
      tgt_rlast   = clint_rlast_i;
    end
    own_rready = owner_lsu_q ? lsu_rready_i : ifu_rready_i;
  end

  // Transaction FSM with latched request fields, owner and target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      target_q    <= TgtNone;
      owner_lsu_q <= 1'b0;
      addr_q      <= 32'd0;
      id_q        <= 4'd0;
      len_q       <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            owner_lsu_q <= grant_lsu;
            addr_q      <= win_addr;
            id_q        <= win_id;
            len_q       <= win_len;
            target_q    <= win_target;
            state_q     <= (win_target == TgtNone) ? StErr : StAr;
          end
        end
        StAr: begin
          if (tgt_arready) state_q <= StR;
        end
        StR: begin
          if (tgt_rvalid && own_rready && tgt_rlast) state_q <= StIdle;
        end
        StErr: begin
          if (own_rready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Owner-bound response beat before steering to IFU or LSU.
  logic        r_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  // Output decode: everything not driven by the current state stays 0.
  always_comb begin
    ifu_arready_o   = 1'b0;
    lsu_arready_o   = 1'b0;
    mem_araddr_o    = 32'd0;
    mem_arid_o      = 4'd0;
    mem_arlen_o     = 8'd0;
    mem_arvalid_o   = 1'b0;
    mem_rready_o    = 1'b0;
    clint_araddr_o  = 32'd0;
    clint_arvalid_o = 1'b0;
    clint_rready_o  = 1'b0;
    r_valid         = 1'b0;
    r_data          = 64'd0;
    r_resp          = 2'b00;
    r_last          = 1'b0;
    r_id            = 4'd0;

    unique case (state_q)
      StIdle: begin
        ifu_arready_o = req_any & ~grant_lsu;
        lsu_arready_o = grant_lsu;
      end
      StAr: begin
        if (target_q == TgtMem) begin
          mem_arvalid_o = 1'b1;
          mem_araddr_o  = addr_q;
          mem_arid_o    = id_q;
          mem_arlen_o   = len_q;
        end else if (target_q == TgtClint) begin
          clint_arvalid_o = 1'b1;
          clint_araddr_o  = addr_q;
        end
      end
      StR: begin
        r_valid = tgt_rvalid;
        r_data  = tgt_rdata;
        r_resp  = tgt_rresp;
        r_last  = tgt_rlast;
        r_id    = id_q;
        if (target_q == TgtMem) begin
          mem_rready_o = own_rready;
        end else if (target_q == TgtClint) begin
          clint_rready_o = own_rready;
        end
      end
      StErr: begin
        // Single DECERR beat regardless of the requested length.
        r_valid = 1'b1;
        r_resp  = 2'b11;
        r_last  = 1'b1;
        r_id    = id_q;
      end
      default: ;
    endcase
  end

  // Steer the response beat to the owning master only.
  always_comb begin
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = 64'd0;
    ifu_rresp_o  = 2'b00;
    ifu_rlast_o  = 1'b0;
    ifu_rid_o    = 4'd0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = 64'd0;
    lsu_rresp_o  = 2'b00;
    lsu_rlast_o  = 1'b0;
    lsu_rid_o    = 4'd0;
    if (owner_lsu_q) begin
      lsu_rvalid_o = r_valid;
      lsu_rdata_o  = r_data;
      lsu_rresp_o  = r_resp;
      lsu_rlast_o  = r_last;
      lsu_rid_o    = r_id;
    end else begin
      ifu_rvalid_o = r_valid;
      ifu_rdata_o  = r_data;
      ifu_rresp_o  = r_resp;
      ifu_rlast_o  = r_last;
      ifu_rid_o    = r_id;
    end
  end

endmodule
